// File: rtl/onewire_master_seq.sv
`timescale 1ns/1ps
// Purpose: 1-Wire bus master sequencer (RESET / WRITE_BYTE / READ_BYTE / NOP) with open-drain slot timing.
// Latency: RESET tRSTL+tRSTH, byte ops 8*tSLOT, NOP 1 cycle from accept to rsp_valid.
// Backpressure: cmd_ready low while a command runs; cmd_valid is ignored while busy, rsp has no ready.
//
// Ports:
//   clk, nRst            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_op (00 RESET, 01 WRITE, 10 READ, 11 NOP)
//   cmd_od, cmd_data     overdrive select and write byte, latched at accept
//   rsp_valid            one-cycle completion pulse with rsp_data / rsp_presence / rsp_short
//   IO_i, IO_o           bus level (async, synchronized here) and bus drive (0 = pull low)
module onewire_master_seq #(
  parameter int CLKS_PER_US = 50,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_od,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       rsp_short,
  input  logic       IO_i,
  output logic       IO_o
);

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_HIGH,
    S_SLOT_LOW,
    S_SLOT_HIGH,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [1:0]       op_q;
  logic             od_q;
  logic [7:0]       data_q;
  logic [7:0]       shreg;
  logic             pres_q;
  logic             io_s1, io_s2;
  logic             io_o_q;
  logic             accept;
  logic             done_entry;

  logic [CNT_W-1:0] t_rstl, t_pds, t_rsth, t_low, t_rds, t_slot;

  function automatic logic [CNT_W-1:0] us_to_clk(input int t_us);
    return CNT_W'(t_us * CLKS_PER_US);
  endfunction

  // Speed is taken from the latched od bit, so it can only change between commands.
  always_comb begin
    t_rstl = od_q ? us_to_clk(50) : us_to_clk(480);
    t_pds  = od_q ? us_to_clk(8)  : us_to_clk(70);
    t_rsth = od_q ? us_to_clk(48) : us_to_clk(480);
    t_rds  = od_q ? us_to_clk(2)  : us_to_clk(15);
    t_slot = od_q ? us_to_clk(10) : us_to_clk(70);
    // Read slots use the short low pulse, like a write-1.
    if ((op_q == OP_READ) || data_q[bit_cnt])
      t_low = od_q ? us_to_clk(1) : us_to_clk(6);
    else
      t_low = od_q ? us_to_clk(8) : us_to_clk(60);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          cnt_n  = '0;
          bit_n  = '0;
          case (cmd_op)
            OP_RESET:         state_n = S_RST_LOW;
            OP_WRITE, OP_READ: state_n = S_SLOT_LOW;
            default:          state_n = S_DONE;
          endcase
        end
      end
      S_RST_LOW: begin
        if (cnt == t_rstl - 1'b1) begin
          state_n = S_RST_HIGH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RST_HIGH: begin
        if (cnt == t_rsth - 1'b1) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_SLOT_LOW: begin
        // Counter runs across the whole slot; low/high split is only a state change.
        cnt_n = cnt + 1'b1;
        if (cnt == t_low - 1'b1) state_n = S_SLOT_HIGH;
      end
      S_SLOT_HIGH: begin
        if (cnt == t_slot - 1'b1) begin
          cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = S_DONE;
          end else begin
            state_n = S_SLOT_LOW;
            bit_n   = bit_cnt + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    cmd_ready  = (state == S_IDLE);
    rsp_valid  = (state == S_DONE);
    done_entry = (state_n == S_DONE) && (state != S_DONE);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt          <= '0;
      bit_cnt      <= '0;
      op_q         <= 2'b11;
      od_q         <= 1'b0;
      data_q       <= '0;
      shreg        <= '0;
      pres_q       <= 1'b0;
      io_s1        <= 1'b1;
      io_s2        <= 1'b1;
      io_o_q       <= 1'b1;
      rsp_data     <= '0;
      rsp_presence <= 1'b0;
      rsp_short    <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      bit_cnt <= bit_n;
      io_s1   <= IO_i;
      io_s2   <= io_s1;
      // Registered drive: low exactly while the next state is a low phase.
      io_o_q  <= !((state_n == S_RST_LOW) || (state_n == S_SLOT_LOW));
      if (accept) begin
        op_q   <= cmd_op;
        od_q   <= cmd_od;
        data_q <= cmd_data;
      end
      if ((state == S_RST_HIGH) && (cnt == t_pds))
        pres_q <= ~io_s2;
      if (((state == S_SLOT_LOW) || (state == S_SLOT_HIGH)) &&
          (op_q == OP_READ) && (cnt == t_rds))
        shreg <= {io_s2, shreg[7:1]};
      // Results change only on completion so they hold between responses.
      if (done_entry) begin
        rsp_data     <= ((state == S_SLOT_HIGH) && (op_q == OP_READ)) ? shreg : 8'h00;
        rsp_presence <= (state == S_RST_HIGH) & pres_q;
        rsp_short    <= (state == S_RST_HIGH) & ~io_s2;
      end
    end
  end

  assign IO_o = io_o_q;

endmodule

// File: tb/tb_onewire_master_seq.sv
`timescale 1ns/1ps
// Bench for onewire_master_seq: behavioural 1-Wire slave plus IO_o timing monitor.
// Runs with a reduced CLKS_PER_US so every timing is us * CPU cycles.
module tb_onewire_master_seq;

  localparam int CPU = 10;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b11;
  logic       cmd_od = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rsp_valid, rsp_presence, rsp_short, IO_i, IO_o;
  logic [7:0] rsp_data;

  logic slave_low = 1'b0;
  logic force_low = 1'b0;
  logic pres_en = 1'b0;
  logic slv_od = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int low_q[$];
  int fall_q[$];
  bit rd_q[$];

  assign IO_i = IO_o & ~slave_low & ~force_low;

  onewire_master_seq #(.CLKS_PER_US(CPU), .CNT_W(16)) dut (
    .clk(clk), .nRst(nRst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_od(cmd_od), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_presence(rsp_presence), .rsp_short(rsp_short),
    .IO_i(IO_i), .IO_o(IO_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int us(input logic od, input int std_us, input int od_us);
    return (od ? od_us : std_us) * CPU;
  endfunction

  // Slave model and monitor: records every IO_o low run and falling edge;
  // answers a long reset pulse with a presence pulse and read slots with queued bits.
  initial begin
    int  run, hold, pres_wait, pres_cnt;
    logic io_prev;
    run = 0; hold = 0; pres_wait = 0; pres_cnt = 0; io_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (pres_wait > 0) begin
        pres_wait--;
        if (pres_wait == 0) pres_cnt = us(slv_od, 120, 14);
      end else if (pres_cnt > 0) begin
        pres_cnt--;
      end
      if (hold > 0) hold--;
      if (!IO_o && io_prev) begin
        fall_q.push_back(cyc);
        if (rd_q.size() > 0) begin
          if (rd_q.pop_front() == 1'b0) hold = us(slv_od, 40, 6);
        end
      end
      if (!IO_o) begin
        run++;
      end else if (run > 0) begin
        low_q.push_back(run);
        if (pres_en && run >= us(slv_od, 400, 40)) pres_wait = us(slv_od, 20, 2);
        run = 0;
      end
      io_prev = IO_o;
      slave_low = (hold > 0) || (pres_cnt > 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [1:0] op, input logic od, input logic [7:0] d);
    for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge clk);
    if (cmd_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL send_ready: cmd_ready=%b, expected 1 within 100 cycles", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_od = od; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_od = 1'($urandom); cmd_data = 8'($urandom);
  endtask

  task automatic wait_rsp(input int budget, output int lat, output logic [7:0] d,
                          output logic p, output logic s);
    logic got;
    got = 1'b0; lat = -1; d = 8'h00; p = 1'b0; s = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1; lat = i; d = rsp_data; p = rsp_presence; s = rsp_short;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (IO_o !== 1'b1) begin miscompares++; $display("FAIL rst_io_in_reset: IO_o=%b, expected 1", IO_o); end
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b, expected 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b, expected 0", rsp_valid); end
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL rst_rsp_data: got %h, expected 00", rsp_data); end
    vectors++; if ({rsp_presence, rsp_short} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b%b, expected 00", rsp_presence, rsp_short); end
    vectors++; if (IO_o !== 1'b1) begin miscompares++; $display("FAIL rst_io: IO_o=%b, expected 1", IO_o); end
  endtask

  task automatic test_std_reset_presence();
    int lat; logic [7:0] d; logic p, s;
    pres_en = 1'b1; slv_od = 1'b0; low_q.delete(); fall_q.delete();
    send_cmd(2'b00, 1'b0, 8'($urandom));
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL busy_after_accept: cmd_ready=%b, expected 0", cmd_ready); end
    vectors++; if (IO_o !== 1'b0) begin miscompares++; $display("FAIL low_after_accept: IO_o=%b, expected 0", IO_o); end
    wait_rsp(us(0, 960, 98) + 100, lat, d, p, s);
    vectors++; if (lat != us(0, 480, 50) + us(0, 480, 48)) begin miscompares++; $display("FAIL std_reset_latency: got %0d, expected %0d", lat, us(0, 480, 50) + us(0, 480, 48)); end
    vectors++; if (low_q.size() < 1 || low_q[0] != us(0, 480, 50)) begin miscompares++; $display("FAIL std_reset_low: got %0d runs first %0d, expected %0d", low_q.size(), (low_q.size() > 0) ? low_q[0] : -1, us(0, 480, 50)); end
    vectors++; if ({p, s} !== 2'b10) begin miscompares++; $display("FAIL std_reset_flags: presence=%b short=%b, expected 1 0", p, s); end
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL std_reset_data: got %h, expected 00", d); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_rsp: got %b, expected 1", cmd_ready); end
    pres_en = 1'b0;
  endtask

  task automatic test_write();
    logic [7:0] wd, d; logic od, p, s; int lat, exp_low;
    for (int t = 0; t < 4; t++) begin
      wd = (t == 0) ? 8'hA5 : 8'($urandom);
      od = (t == 0) ? 1'b0 : 1'($urandom);
      low_q.delete(); fall_q.delete();
      send_cmd(2'b01, od, wd);
      wait_rsp(8 * us(0, 70, 10) + 100, lat, d, p, s);
      vectors++; if (lat != 8 * us(od, 70, 10)) begin miscompares++; $display("FAIL write_latency: byte %h od %b got %0d, expected %0d", wd, od, lat, 8 * us(od, 70, 10)); end
      vectors++;
      if (low_q.size() != 8 || fall_q.size() != 8) begin
        miscompares++; $display("FAIL write_slot_count: got %0d lows %0d edges, expected 8", low_q.size(), fall_q.size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          exp_low = wd[i] ? us(od, 6, 1) : us(od, 60, 8);
          vectors++; if (low_q[i] != exp_low) begin miscompares++; $display("FAIL write_low_width: byte %h bit %0d got %0d, expected %0d", wd, i, low_q[i], exp_low); end
        end
        for (int i = 1; i < 8; i++) begin
          vectors++; if (fall_q[i] - fall_q[i-1] != us(od, 70, 10)) begin miscompares++; $display("FAIL write_slot_period: bit %0d got %0d, expected %0d", i, fall_q[i] - fall_q[i-1], us(od, 70, 10)); end
        end
      end
      vectors++; if ({d, p, s} !== 10'h000) begin miscompares++; $display("FAIL write_rsp: data %h p %b s %b, expected 00 0 0", d, p, s); end
    end
  endtask

  task automatic test_read();
    logic [7:0] rb, d; logic od, p, s; int lat;
    for (int t = 0; t < 4; t++) begin
      rb = (t == 0) ? 8'h2D : 8'($urandom);
      od = 1'($urandom);
      slv_od = od; low_q.delete(); fall_q.delete(); rd_q.delete();
      for (int i = 0; i < 8; i++) rd_q.push_back(rb[i]);
      send_cmd(2'b10, od, 8'($urandom));
      wait_rsp(8 * us(0, 70, 10) + 100, lat, d, p, s);
      vectors++; if (d !== rb) begin miscompares++; $display("FAIL read_data: od %b got %h, expected %h", od, d, rb); end
      vectors++; if (lat != 8 * us(od, 70, 10)) begin miscompares++; $display("FAIL read_latency: got %0d, expected %0d", lat, 8 * us(od, 70, 10)); end
      vectors++; if (low_q.size() != 8 || low_q[0] != us(od, 6, 1) || low_q[7] != us(od, 6, 1)) begin miscompares++; $display("FAIL read_low_width: %0d runs first %0d, expected 8 of %0d", low_q.size(), (low_q.size() > 0) ? low_q[0] : -1, us(od, 6, 1)); end
      vectors++; if ({p, s} !== 2'b00) begin miscompares++; $display("FAIL read_flags: p %b s %b, expected 0 0", p, s); end
    end
  endtask

  task automatic test_od_pullup();
    int lat; logic [7:0] d; logic p, s;
    pres_en = 1'b0; slv_od = 1'b1; low_q.delete(); fall_q.delete(); rd_q.delete();
    send_cmd(2'b00, 1'b1, 8'h00);
    wait_rsp(us(1, 960, 98) + 100, lat, d, p, s);
    vectors++; if ({p, s} !== 2'b00) begin miscompares++; $display("FAIL od_reset_flags: presence=%b short=%b, expected 0 0", p, s); end
    vectors++; if (low_q.size() < 1 || low_q[0] != us(1, 480, 50)) begin miscompares++; $display("FAIL od_reset_low: first run %0d, expected %0d", (low_q.size() > 0) ? low_q[0] : -1, us(1, 480, 50)); end
    vectors++; if (lat != us(1, 480, 50) + us(1, 480, 48)) begin miscompares++; $display("FAIL od_reset_latency: got %0d, expected %0d", lat, us(1, 480, 50) + us(1, 480, 48)); end
    fall_q.delete();
    send_cmd(2'b10, 1'b1, 8'h00);
    wait_rsp(8 * us(1, 70, 10) + 100, lat, d, p, s);
    vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL od_read_pullup: got %h, expected ff", d); end
    vectors++; if (fall_q.size() != 8 || fall_q[7] - fall_q[0] != 7 * us(1, 70, 10)) begin miscompares++; $display("FAIL od_slot_period: %0d edges, expected 8 at %0d spacing", fall_q.size(), us(1, 70, 10)); end
  endtask

  task automatic test_short_and_busy();
    int nrsp, lat, budget; logic p, s;
    nrsp = 0; lat = -1; p = 1'b0; s = 1'b0; budget = us(1, 960, 98) + 60;
    force_low = 1'b1;
    send_cmd(2'b00, 1'b1, 8'h00);
    for (int i = 0; i < budget; i++) begin
      cmd_valid = (i == 20) || (i == 700);
      cmd_op = 2'b10;
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (nrsp == 1) begin lat = i; p = rsp_presence; s = rsp_short; end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0; force_low = 1'b0;
    vectors++; if (nrsp != 1) begin miscompares++; $display("FAIL busy_ignored: got %0d responses, expected 1", nrsp); end
    vectors++; if (lat != us(1, 480, 50) + us(1, 480, 48)) begin miscompares++; $display("FAIL short_latency: got %0d, expected %0d", lat, us(1, 480, 50) + us(1, 480, 48)); end
    vectors++; if (s !== 1'b1) begin miscompares++; $display("FAIL short_flag: got %b, expected 1", s); end
    vectors++; if (p !== 1'b1) begin miscompares++; $display("FAIL short_presence: got %b, expected 1", p); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL short_ready: got %b, expected 1", cmd_ready); end
  endtask

  task automatic test_mid_reset();
    int lat; logic [7:0] d; logic p, s;
    pres_en = 1'b0; slv_od = 1'b0; rd_q.delete();
    send_cmd(2'b01, 1'b0, 8'h00);
    repeat (50) @(negedge clk);
    vectors++; if (IO_o !== 1'b0) begin miscompares++; $display("FAIL mid_slot_low: IO_o=%b, expected 0", IO_o); end
    nRst = 1'b0;
    #1;
    vectors++; if (IO_o !== 1'b1) begin miscompares++; $display("FAIL mid_reset_release: IO_o=%b, expected 1", IO_o); end
    vectors++; if ({cmd_ready, rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL mid_reset_ctrl: ready %b valid %b, expected 1 0", cmd_ready, rsp_valid); end
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready: got %b, expected 1", cmd_ready); end
    pres_en = 1'b1; slv_od = 1'b1; low_q.delete(); fall_q.delete();
    send_cmd(2'b00, 1'b1, 8'h00);
    wait_rsp(us(1, 960, 98) + 100, lat, d, p, s);
    vectors++; if ({p, s} !== 2'b10) begin miscompares++; $display("FAIL after_reset_flags: presence=%b short=%b, expected 1 0", p, s); end
    vectors++; if (low_q.size() < 1 || low_q[0] != us(1, 480, 50)) begin miscompares++; $display("FAIL after_reset_low: first run %0d, expected %0d", (low_q.size() > 0) ? low_q[0] : -1, us(1, 480, 50)); end
    pres_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] rb, d; logic p, s;
    rb = 8'($urandom); slv_od = 1'b1; rd_q.delete();
    for (int i = 0; i < 8; i++) rd_q.push_back(rb[i]);
    send_cmd(2'b10, 1'b1, 8'h00);
    wait_rsp(8 * us(1, 70, 10) + 100, lat, d, p, s);
    repeat ($urandom_range(5, 20)) @(negedge clk);
    vectors++; if (rsp_data !== rb) begin miscompares++; $display("FAIL rsp_hold: got %h, expected %h", rsp_data, rb); end
    for (int t = 0; t < 2; t++) begin
      send_cmd(2'b11, 1'($urandom), 8'($urandom));
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL nop_latency: rsp_valid=%b one cycle after accept, expected 1", rsp_valid); end
      vectors++; if ({rsp_data, rsp_presence, rsp_short} !== 10'h000) begin miscompares++; $display("FAIL nop_rsp: data %h p %b s %b, expected 00 0 0", rsp_data, rsp_presence, rsp_short); end
      @(negedge clk);
      vectors++; if ({rsp_valid, cmd_ready} !== 2'b01) begin miscompares++; $display("FAIL nop_pulse: valid %b ready %b, expected 0 1", rsp_valid, cmd_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_std_reset_presence();
    test_write();
    test_read();
    test_od_pullup();
    test_short_and_busy();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
